game_wave_scheduler: RTL and testbench
======================================

Name: game_wave_scheduler

Overview:
- Sequences the falling-target sprite for the dodge game: decides when a target spawns, where it spawns, its velocity and the difficulty level.
- Counts dodged targets, tracks lives and declares game over.
- Sits between game_random, the collision/overlap logic and the target game_sprite_top instance. Its outputs drive that instance's write_xy/write_dxy/enable_update and write_x/y/dx/dy.
- The master FSM keeps ownership of the torpedo; this block owns the target.

Parameters:
- screen_width, 640, horizontal resolution; screen_width-8 must be >= 512.
- screen_height, 480, vertical resolution.
- GAP_CYCLES, 1000000, idle clocks between a target leaving the screen and the next spawn.
- DODGES_PER_LEVEL, 5, dodges needed per speed increment.
- MAX_SPEED, 7, speed saturation value (max 7).
- START_LIVES, 3, lives loaded at game start (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- launch_key  in  1  start request, level; rising edge used
- pause_key  in  1  pause toggle, level; rising edge used (see Optional Feature)
- collision  in  1  target/torpedo overlap, level
- target_within_screen  in  1  target sprite inside visible area
- random  in  16  free-running LFSR value
- spawn_write  out  1  one-cycle pulse; drives target write_xy and write_dxy
- spawn_x  out  $clog2(screen_width)  spawn X
- spawn_y  out  $clog2(screen_height)  spawn Y
- spawn_dx  out  4  signed X velocity
- spawn_dy  out  4  signed Y velocity
- enable_update  out  1  target motion enable
- speed  out  4  current level, 1..MAX_SPEED
- dodge_count  out  16  targets dodged this game
- lives  out  2  remaining lives
- game_over  out  1  high in OVER state

Behaviour:
- Reset (rst==0 at posedge clk): state IDLE.
  - spawn_write=0, enable_update=0, spawn_x/y/dx/dy=0.
  - speed=1, dodge_count=0, lives=0, game_over=0, edge-detect registers=0.
  - Reset mid-operation aborts any state immediately; there is no pending spawn.
- FSM states: IDLE, SPAWN, FLIGHT, GAP, HIT, OVER.
- IDLE:
  - launch_key rising edge -> SPAWN.
  - On that transition: lives=START_LIVES, speed=1, dodge_count=0.
- SPAWN: lasts exactly 1 cycle, with spawn_write=1. Next state FLIGHT.
  - spawn_x/y/dx/dy are registered on entry to SPAWN (from random sampled on the transition cycle).
  - They are held stable until the next SPAWN.
- Spawn rules, with r = sampled random:
  - r[7:6]=00: x = r[4:0]; dx = +speed; dy = +speed.
  - r[7:6]=01: x = screen_width-16-r[4:0]; dx = -speed (two's complement, 4-bit); dy = +speed.
  - r[7:6]=1x: x = r[9:0] if r[9:0] < screen_width-8, else r[9:0]-(screen_width-8); dx = 0; dy = +speed.
    - This is a single conditional subtract; no divider.
  - y = screen_height/10 + r[5:0] in all lanes.
- FLIGHT: enable_update=1.
  - collision=1 -> HIT. Collision has priority over exit in the same cycle.
  - Else target_within_screen falling edge -> dodge_count+1 (wraps FFFF->0) -> GAP.
  - Speed update on a dodge: if the new dodge count is a multiple of DODGES_PER_LEVEL and speed<MAX_SPEED, speed+1. Speed saturates at MAX_SPEED.
  - The within-screen edge detector is primed during SPAWN, so a spawn-cycle glitch does not count.
- GAP: enable_update=0; counter runs 0..GAP_CYCLES-1, then -> SPAWN. The counter is cleared on entry.
- HIT: enable_update=0; lives-1 and speed=1, applied once on entry.
  - If the new lives==0 -> OVER.
  - Else hold GAP_CYCLES (same counter) -> SPAWN.
- OVER: game_over=1; all counters frozen.
  - launch_key rising edge -> IDLE-equivalent restart: go directly to SPAWN with lives/speed/dodge_count reloaded.
- launch_key edges outside IDLE/OVER are ignored.
- Lives never underflow below 0.

Optional Feature:
- GAME_WAVE_PAUSE_EN defined:
  - A pause_key rising edge toggles a paused flag in FLIGHT, GAP and HIT.
  - While paused: enable_update=0, the GAP counter is frozen, collision and exit are ignored, and the state is held.
  - The paused flag is cleared by reset, on entry to OVER, and at game start.
- Undefined: pause_key is ignored (port still present); paused flag is constant 0 and is optimised away.

Decomposition:
- Package game_wave_pkg:
  - state enum type.
  - lane encoding (LANE_LEFT, LANE_RIGHT, LANE_DOWN).
  - speed width constant (4).
  - lives width constant (2).
- Sub-module game_wave_spawn_calc: registered lane/position/velocity computation from random and speed, loaded on a load strobe.

Test Plan:
- Reset low, then launch_key rising edge with random=16'h0013 -> spawn_write single pulse 2 cycles after the edge; spawn_x=19, dx=+1, dy=+1, lives=3, speed=1.
- GAP_CYCLES=4, DODGES_PER_LEVEL=5, five exits (target_within_screen 1->0) -> dodge_count=5, speed=2; each next spawn_write occurs exactly 4+1 cycles after the exit.
- random[9:0]=10'd1000, random[7:6]=11, screen_width=640 -> spawn_x=368, dx=0.
- collision and target_within_screen falling edge in the same cycle, lives=3 -> state HIT, lives=2, dodge_count unchanged, speed=1.
- Three collisions -> lives=0, game_over=1, no further spawn_write; launch_key edge -> spawn_write, lives=3, dodge_count=0.
- rst low for one cycle mid-FLIGHT at speed=4 -> next cycle all outputs at reset values, state IDLE. With GAME_WAVE_PAUSE_EN: pause in GAP holds counter value; unpause resumes and spawns after the remaining count.

Source files
------------

// File: rtl/game_wave_scheduler_pkg.sv
// Shared types for the dodge-game target scheduler: FSM states, spawn lanes
// and the widths of the speed and lives fields.
package game_wave_pkg;

  localparam int SPEED_W = 4;
  localparam int LIVES_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FLIGHT,
    ST_GAP,
    ST_HIT,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    LANE_LEFT  = 2'd0,
    LANE_RIGHT = 2'd1,
    LANE_DOWN  = 2'd2
  } lane_t;

  // Lane select comes from two random bits; both 1x codes fall straight down.
  function automatic lane_t lane_of(input logic [1:0] sel);
    if (sel[1])      return LANE_DOWN;
    else if (sel[0]) return LANE_RIGHT;
    else             return LANE_LEFT;
  endfunction

endpackage

// File: rtl/game_wave_scheduler_if.sv
// Target sprite control bundle: spawn write strobe, spawn position/velocity
// and the motion enable, as consumed by the target game_sprite_top.
interface game_wave_scheduler_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic                 spawn_write;
  logic [XW-1:0]        spawn_x;
  logic [YW-1:0]        spawn_y;
  logic signed [3:0]    spawn_dx;
  logic signed [3:0]    spawn_dy;
  logic                 enable_update;

  modport master (
    output spawn_write, spawn_x, spawn_y, spawn_dx, spawn_dy, enable_update
  );

  modport slave (
    input spawn_write, spawn_x, spawn_y, spawn_dx, spawn_dy, enable_update
  );
endinterface

// File: rtl/game_wave_spawn_calc.sv
// Spawn position/velocity generator: picks a lane from the random word and
// registers x/y/dx/dy when load is strobed, holding them until the next load.
module game_wave_spawn_calc
  import game_wave_pkg::*;
#(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int XW            = $clog2(screen_width),
  parameter int YW            = $clog2(screen_height)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [15:0]               random,
  input  logic [SPEED_W-1:0]        speed,
  output logic [XW-1:0]             x,
  output logic [YW-1:0]             y,
  output logic signed [SPEED_W-1:0] dx,
  output logic signed [SPEED_W-1:0] dy
);

  lane_t                      lane;
  logic signed [SPEED_W-1:0]  mag;
  logic [XW-1:0]              x_c;
  logic [YW-1:0]              y_c;
  logic signed [SPEED_W-1:0]  dx_c;
  logic signed [SPEED_W-1:0]  dy_c;

  logic unused_rand;
  assign unused_rand = ^random[15:10];

  always_comb begin
    lane = lane_of(random[7:6]);
    mag  = signed'(speed);
    x_c  = '0;
    dx_c = '0;
    dy_c = mag;
    y_c  = YW'(screen_height / 10) + YW'(random[5:0]);
    case (lane)
      LANE_LEFT: begin
        x_c  = XW'(random[4:0]);
        dx_c = mag;
      end
      LANE_RIGHT: begin
        x_c  = XW'(screen_width - 16) - XW'(random[4:0]);
        dx_c = -mag;
      end
      default: begin
        // r[9:0] < 2*(screen_width-8), so one conditional subtract wraps it.
        if (int'(random[9:0]) < screen_width - 8)
          x_c = XW'(random[9:0]);
        else
          x_c = XW'(int'(random[9:0]) - (screen_width - 8));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x  <= '0;
      y  <= '0;
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      x  <= x_c;
      y  <= y_c;
      dx <= dx_c;
      dy <= dy_c;
    end
  end

endmodule

// File: rtl/game_wave_scheduler.sv
// Target wave scheduler for the dodge game: spawn timing, lanes, difficulty,
// dodge count, lives and game over. Optional pause support: GAME_WAVE_PAUSE_EN.
module game_wave_scheduler
  import game_wave_pkg::*;
#(
  parameter int screen_width     = 640,
  parameter int screen_height    = 480,
  parameter int GAP_CYCLES       = 1000000,
  parameter int DODGES_PER_LEVEL = 5,
  parameter int MAX_SPEED        = 7,
  parameter int START_LIVES      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  input  logic                 pause_key,
  input  logic                 collision,
  input  logic                 target_within_screen,
  input  logic [15:0]          random,
  game_wave_scheduler_if.master tgt,
  output logic [SPEED_W-1:0]   speed,
  output logic [15:0]          dodge_count,
  output logic [LIVES_W-1:0]   lives,
  output logic                 game_over
);

  localparam int XW    = $clog2(screen_width);
  localparam int YW    = $clog2(screen_height);
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int LVL_W = (DODGES_PER_LEVEL > 1) ? $clog2(DODGES_PER_LEVEL) : 1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [LVL_W-1:0]     lvl, lvl_nxt;
  logic [LIVES_W-1:0]   lives_nxt;
  logic [SPEED_W-1:0]   speed_nxt;
  logic [15:0]          dodge_nxt;
  logic                 load, start;
  logic                 launch_s, launch_q, within_q;
  logic                 launch_rise, within_fall, gap_done, level_up;
  logic                 paused;

  logic [XW-1:0]             sx;
  logic [YW-1:0]             sy;
  logic signed [SPEED_W-1:0] sdx, sdy;

  // launch_key is a human input: one sync flop, then edge detect.
  assign launch_rise = launch_s & ~launch_q;
  assign within_fall = within_q & ~target_within_screen;
  assign gap_done    = (cnt == CNT_W'(GAP_CYCLES - 1));
  // lvl tracks dodge_count mod DODGES_PER_LEVEL; the 16-bit wrap lands on 0.
  assign level_up    = (lvl == LVL_W'(DODGES_PER_LEVEL - 1)) || (dodge_count == 16'hFFFF);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lvl_nxt   = lvl;
    lives_nxt = lives;
    speed_nxt = speed;
    dodge_nxt = dodge_count;
    load      = 1'b0;
    start     = 1'b0;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (launch_rise) start = 1'b1;
      end
      ST_SPAWN: state_nxt = ST_FLIGHT;
      ST_FLIGHT: begin
        if (!paused) begin
          if (collision) begin
            state_nxt = ST_HIT;
            lives_nxt = (lives != '0) ? lives - LIVES_W'(1) : '0;
            speed_nxt = SPEED_W'(1);
            cnt_nxt   = '0;
          end else if (within_fall) begin
            state_nxt = ST_GAP;
            dodge_nxt = dodge_count + 16'd1;
            cnt_nxt   = '0;
            if (level_up) begin
              lvl_nxt = '0;
              if (speed < SPEED_W'(MAX_SPEED)) speed_nxt = speed + SPEED_W'(1);
            end else begin
              lvl_nxt = lvl + LVL_W'(1);
            end
          end
        end
      end
      ST_GAP, ST_HIT: begin
        if (state == ST_HIT && lives == '0) begin
          state_nxt = ST_OVER;
        end else if (!paused) begin
          if (gap_done) begin
            state_nxt = ST_SPAWN;
            load      = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) begin
      state_nxt = ST_SPAWN;
      load      = 1'b1;
      lives_nxt = LIVES_W'(START_LIVES);
      speed_nxt = SPEED_W'(1);
      dodge_nxt = '0;
      lvl_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lvl         <= '0;
      lives       <= '0;
      speed       <= SPEED_W'(1);
      dodge_count <= '0;
      launch_s    <= 1'b0;
      launch_q    <= 1'b0;
      within_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lvl         <= lvl_nxt;
      lives       <= lives_nxt;
      speed       <= speed_nxt;
      dodge_count <= dodge_nxt;
      launch_s    <= launch_key;
      launch_q    <= launch_s;
      within_q    <= target_within_screen;
    end
  end

`ifdef GAME_WAVE_PAUSE_EN
  logic pause_s, pause_q;
  logic pause_rise, pausable;

  assign pause_rise = pause_s & ~pause_q;
  assign pausable   = (state == ST_FLIGHT) || (state == ST_GAP) || (state == ST_HIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_s <= 1'b0;
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_s <= pause_key;
      pause_q <= pause_s;
      if (start || (state_nxt == ST_OVER))
        paused <= 1'b0;
      else if (pause_rise && pausable)
        paused <= ~paused;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause_key;
  assign paused       = 1'b0;
`endif

  game_wave_spawn_calc #(
    .screen_width (screen_width),
    .screen_height(screen_height),
    .XW           (XW),
    .YW           (YW)
  ) u_spawn (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .random(random),
    .speed (speed_nxt),
    .x     (sx),
    .y     (sy),
    .dx    (sdx),
    .dy    (sdy)
  );

  assign tgt.spawn_write   = (state == ST_SPAWN);
  assign tgt.enable_update = (state == ST_FLIGHT) && !paused;
  assign tgt.spawn_x       = sx;
  assign tgt.spawn_y       = sy;
  assign tgt.spawn_dx      = sdx;
  assign tgt.spawn_dy      = sdy;
  assign game_over         = (state == ST_OVER);

endmodule

// File: tb/tb_game_wave_scheduler.sv
// Self-checking bench for game_wave_scheduler with a small game-rule model.
module tb_game_wave_scheduler;

  localparam int SW = 640, SH = 480, GAP = 4, DPL = 5, MAXS = 7, SL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        launch_key = 1'b0;
  logic        pause_key = 1'b0;
  logic        collision = 1'b0;
  logic        target_within_screen = 1'b0;
  logic [15:0] random = 16'h0;
  logic [3:0]  speed;
  logic [15:0] dodge_count;
  logic [1:0]  lives;
  logic        game_over;

  game_wave_scheduler_if #(.XW($clog2(SW)), .YW($clog2(SH))) tgt();

  game_wave_scheduler #(
    .screen_width(SW), .screen_height(SH), .GAP_CYCLES(GAP),
    .DODGES_PER_LEVEL(DPL), .MAX_SPEED(MAXS), .START_LIVES(SL)
  ) dut (
    .clk(clk), .rst(rst), .launch_key(launch_key), .pause_key(pause_key),
    .collision(collision), .target_within_screen(target_within_screen),
    .random(random), .tgt(tgt), .speed(speed), .dodge_count(dodge_count),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_lives = 0, m_speed = 1, m_dodge = 0;

  // Spawn rules straight from the game description.
  function automatic void model_spawn(input logic [15:0] r, input int spd,
                                      output int x, output int y, output int dx, output int dy);
    int lane;
    lane = int'(r[7:6]);
    y  = SH / 10 + int'(r[5:0]);
    dy = spd;
    if (lane == 0) begin x = int'(r[4:0]); dx = spd; end
    else if (lane == 1) begin x = SW - 16 - int'(r[4:0]); dx = -spd; end
    else begin x = int'(r[9:0]) % (SW - 8); dx = 0; end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_spawn(input int limit, output int n);
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) target_within_screen = 1'b1;
    end while (tgt.spawn_write !== 1'b1 && n < limit);
    if (tgt.spawn_write !== 1'b1) n = -1;
  endtask

  task automatic launch_game(input logic [15:0] r);
    int n, ex, ey, edx, edy;
    random = r; launch_key = 1'b1;
    wait_spawn(10, n);
    launch_key = 1'b0;
    m_lives = SL; m_speed = 1; m_dodge = 0;
    model_spawn(r, m_speed, ex, ey, edx, edy);
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL launch_latency: got %0d want 2", n); end
    n_cmp++; if (int'(lives) !== m_lives) begin n_err++; $display("FAIL launch_lives: got %0d want %0d", lives, m_lives); end
    n_cmp++; if (int'(speed) !== m_speed) begin n_err++; $display("FAIL launch_speed: got %0d want %0d", speed, m_speed); end
    n_cmp++; if (int'(dodge_count) !== m_dodge) begin n_err++; $display("FAIL launch_dodge: got %0d want %0d", dodge_count, m_dodge); end
    n_cmp++; if (int'(tgt.spawn_x) !== ex) begin n_err++; $display("FAIL launch_x: got %0d want %0d", tgt.spawn_x, ex); end
    n_cmp++; if (int'(tgt.spawn_y) !== ey) begin n_err++; $display("FAIL launch_y: got %0d want %0d", tgt.spawn_y, ey); end
    n_cmp++; if (int'(tgt.spawn_dx) !== edx) begin n_err++; $display("FAIL launch_dx: got %0d want %0d", tgt.spawn_dx, edx); end
    n_cmp++; if (int'(tgt.spawn_dy) !== edy) begin n_err++; $display("FAIL launch_dy: got %0d want %0d", tgt.spawn_dy, edy); end
    tick();
    n_cmp++; if (tgt.spawn_write !== 1'b0) begin n_err++; $display("FAIL launch_pulse_width: got %b want 0", tgt.spawn_write); end
    n_cmp++; if (tgt.enable_update !== 1'b1) begin n_err++; $display("FAIL flight_enable: got %b want 1", tgt.enable_update); end
  endtask

  // One target leaves the screen; the next spawn is checked against the model.
  task automatic dodge_once(input logic [15:0] r);
    int n, ex, ey, edx, edy;
    random = r;
    repeat ($urandom_range(0, 3)) tick();
    target_within_screen = 1'b0;
    wait_spawn(20, n);
    m_dodge++;
    if (m_dodge % DPL == 0 && m_speed < MAXS) m_speed++;
    model_spawn(r, m_speed, ex, ey, edx, edy);
    n_cmp++; if (n !== GAP + 1) begin n_err++; $display("FAIL gap_latency: got %0d want %0d", n, GAP + 1); end
    n_cmp++; if (int'(dodge_count) !== m_dodge) begin n_err++; $display("FAIL dodge_count: got %0d want %0d", dodge_count, m_dodge); end
    n_cmp++; if (int'(speed) !== m_speed) begin n_err++; $display("FAIL speed: got %0d want %0d", speed, m_speed); end
    n_cmp++; if (int'(tgt.spawn_x) !== ex) begin n_err++; $display("FAIL spawn_x r=%h: got %0d want %0d", r, tgt.spawn_x, ex); end
    n_cmp++; if (int'(tgt.spawn_y) !== ey) begin n_err++; $display("FAIL spawn_y r=%h: got %0d want %0d", r, tgt.spawn_y, ey); end
    n_cmp++; if (int'(tgt.spawn_dx) !== edx) begin n_err++; $display("FAIL spawn_dx r=%h: got %0d want %0d", r, tgt.spawn_dx, edx); end
    n_cmp++; if (int'(tgt.spawn_dy) !== edy) begin n_err++; $display("FAIL spawn_dy r=%h: got %0d want %0d", r, tgt.spawn_dy, edy); end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; target_within_screen = 1'b1;
    tick(); tick();
    n_cmp++; if (tgt.spawn_write !== 1'b0) begin n_err++; $display("FAIL rst_spawn_write: got %b want 0", tgt.spawn_write); end
    n_cmp++; if (tgt.enable_update !== 1'b0) begin n_err++; $display("FAIL rst_enable: got %b want 0", tgt.enable_update); end
    n_cmp++; if ({tgt.spawn_x, tgt.spawn_y, tgt.spawn_dx, tgt.spawn_dy} !== '0) begin n_err++; $display("FAIL rst_spawn_vals: got %0d/%0d/%0d/%0d want 0", tgt.spawn_x, tgt.spawn_y, tgt.spawn_dx, tgt.spawn_dy); end
    n_cmp++; if (speed !== 4'd1) begin n_err++; $display("FAIL rst_speed: got %0d want 1", speed); end
    n_cmp++; if ({dodge_count, lives, game_over} !== '0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d/%b want 0", dodge_count, lives, game_over); end
    rst = 1'b1;
  endtask

  task automatic test_launch();
    launch_game(16'h0013);
    n_cmp++; if (int'(tgt.spawn_x) !== 19) begin n_err++; $display("FAIL launch_x_const: got %0d want 19", tgt.spawn_x); end
  endtask

  task automatic test_dodges();
    for (int i = 0; i < 5; i++) begin
      dodge_once((i == 2) ? 16'd1000 : 16'($urandom));
      if (i == 2) begin
        n_cmp++; if (tgt.spawn_x !== 10'd368 || tgt.spawn_dx !== 4'sd0) begin n_err++; $display("FAIL down_lane_wrap: got x=%0d dx=%0d want 368/0", tgt.spawn_x, tgt.spawn_dx); end
      end
    end
    n_cmp++; if (dodge_count !== 16'd5 || speed !== 4'd2) begin n_err++; $display("FAIL five_dodges: got %0d/%0d want 5/2", dodge_count, speed); end
  endtask

  task automatic test_launch_ignored();
    int spawns = 0;
    launch_key = 1'b1;
    repeat (6) begin tick(); if (tgt.spawn_write === 1'b1) spawns++; end
    launch_key = 1'b0;
    n_cmp++; if (spawns !== 0) begin n_err++; $display("FAIL launch_in_flight: got %0d spawns want 0", spawns); end
    n_cmp++; if (tgt.enable_update !== 1'b1) begin n_err++; $display("FAIL still_flight: got %b want 1", tgt.enable_update); end
  endtask

  // Collision and exit together, then further hits down to game over.
  task automatic test_hits();
    int n;
    int spawns;
    for (int h = 0; h < SL; h++) begin
      random = 16'($urandom);
      collision = 1'b1;
      if (h == 0) target_within_screen = 1'b0;
      tick();
      collision = 1'b0;
      m_lives--; m_speed = 1;
      n_cmp++; if (int'(lives) !== m_lives) begin n_err++; $display("FAIL hit_lives: got %0d want %0d", lives, m_lives); end
      n_cmp++; if (int'(speed) !== 1 || int'(dodge_count) !== m_dodge) begin n_err++; $display("FAIL hit_speed_dodge: got %0d/%0d want 1/%0d", speed, dodge_count, m_dodge); end
      n_cmp++; if (tgt.enable_update !== 1'b0) begin n_err++; $display("FAIL hit_enable: got %b want 0", tgt.enable_update); end
      if (m_lives > 0) begin
        wait_spawn(20, n);
        n_cmp++; if (n !== GAP) begin n_err++; $display("FAIL hit_respawn: got %0d want %0d", n, GAP); end
        n_cmp++; if (int'(tgt.spawn_dy) !== 1) begin n_err++; $display("FAIL hit_respawn_dy: got %0d want 1", tgt.spawn_dy); end
        tick();
      end
    end
    tick();
    n_cmp++; if (game_over !== 1'b1 || lives !== 2'd0) begin n_err++; $display("FAIL game_over: got %b lives=%0d want 1/0", game_over, lives); end
    spawns = 0;
    repeat (20) begin tick(); if (tgt.spawn_write === 1'b1) spawns++; end
    n_cmp++; if (spawns !== 0 || tgt.enable_update !== 1'b0) begin n_err++; $display("FAIL over_quiet: got %0d spawns en=%b want 0/0", spawns, tgt.enable_update); end
    launch_game(16'($urandom));
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL restart_over_flag: got %b want 0", game_over); end
  endtask

  task automatic test_reset_mid();
    int spawns = 0;
    for (int i = 0; i < 3 * DPL; i++) dodge_once(16'($urandom));
    n_cmp++; if (speed !== 4'd4) begin n_err++; $display("FAIL speed_before_reset: got %0d want 4", speed); end
    rst = 1'b0; tick(); rst = 1'b1;
    n_cmp++; if ({tgt.spawn_write, tgt.enable_update, game_over, lives, dodge_count} !== '0 || speed !== 4'd1) begin n_err++; $display("FAIL mid_reset: got sw=%b en=%b go=%b l=%0d d=%0d s=%0d want 0/0/0/0/0/1", tgt.spawn_write, tgt.enable_update, game_over, lives, dodge_count, speed); end
    n_cmp++; if ({tgt.spawn_x, tgt.spawn_y, tgt.spawn_dx, tgt.spawn_dy} !== '0) begin n_err++; $display("FAIL mid_reset_spawn: got %0d/%0d/%0d/%0d want 0", tgt.spawn_x, tgt.spawn_y, tgt.spawn_dx, tgt.spawn_dy); end
    repeat (8) begin tick(); if (tgt.spawn_write === 1'b1) spawns++; end
    n_cmp++; if (spawns !== 0) begin n_err++; $display("FAIL idle_after_reset: got %0d spawns want 0", spawns); end
    launch_game(16'($urandom));
  endtask

`ifdef GAME_WAVE_PAUSE_EN
  task automatic test_pause_gap();
    int k, n;
    k = $urandom_range(3, 8);
    n = 0;
    random = 16'($urandom);
    target_within_screen = 1'b0;
    do begin
      tick(); n++;
      if (n == 1) begin target_within_screen = 1'b1; pause_key = 1'b1; end
      if (n == 2) pause_key = 1'b0;
      if (n == 1 + k) pause_key = 1'b1;
      if (n == 2 + k) pause_key = 1'b0;
    end while (tgt.spawn_write !== 1'b1 && n < 40);
    pause_key = 1'b0;
    m_dodge++;
    if (m_dodge % DPL == 0 && m_speed < MAXS) m_speed++;
    n_cmp++; if (n !== GAP + 1 + k) begin n_err++; $display("FAIL pause_gap_latency: got %0d want %0d", n, GAP + 1 + k); end
    n_cmp++; if (int'(dodge_count) !== m_dodge) begin n_err++; $display("FAIL pause_dodge: got %0d want %0d", dodge_count, m_dodge); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_launch();
    test_dodges();
    test_launch_ignored();
    test_hits();
`ifdef GAME_WAVE_PAUSE_EN
    test_pause_gap();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
